// File: rtl/mac_unit_pkg.sv
// Shared constants and types for the multiply-accumulate unit.
// Holds the default operand width, the derived accumulator width and the accumulator update codes.
package mac_unit_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int ACC_WIDTH_DEF  = 3 * DATA_WIDTH_DEF;

    // Accumulator update selected on each edge once reset is not asserted.
    typedef enum logic [1:0] {
        ACC_HOLD  = 2'd0,
        ACC_CLEAR = 2'd1,
        ACC_ADD   = 2'd2
    } acc_op_e;

    function automatic int acc_width(input int data_width);
        return 3 * data_width;
    endfunction

endpackage

// File: rtl/mac_mult.sv
// Combinational unsigned multiplier.
// Produces the full-width 2*DATA_WIDTH product, so no bits are lost before accumulation.
module mac_mult
    import mac_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic [DATA_WIDTH-1:0]   a,
    input  logic [DATA_WIDTH-1:0]   b,
    output logic [2*DATA_WIDTH-1:0] prod
);

    // Widen both operands first so the multiply is evaluated at the full product width.
    logic [2*DATA_WIDTH-1:0] a_ext;
    logic [2*DATA_WIDTH-1:0] b_ext;

    assign a_ext = {{DATA_WIDTH{1'b0}}, a};
    assign b_ext = {{DATA_WIDTH{1'b0}}, b};
    assign prod  = a_ext * b_ext;

endmodule

// File: rtl/mac_unit.sv
// Multiply-accumulate unit: acc <= acc + Ain*Bin when enabled, wrapping modulo 2^(3*DATA_WIDTH).
// Priority on each edge is reset, then clear, then accumulate, then hold. Cout is the accumulator register.
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    En,
    input  logic                    Clr,
    input  logic [DATA_WIDTH-1:0]   Ain,
    input  logic [DATA_WIDTH-1:0]   Bin,
    output logic [3*DATA_WIDTH-1:0] Cout
);

    localparam int ACC_W = acc_width(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [ACC_W-1:0]        prod_ext;
    logic [ACC_W-1:0]        sum;
    logic [ACC_W-1:0]        acc;
    logic [ACC_W-1:0]        acc_next;
    acc_op_e                 acc_op;

    mac_mult #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mult (
        .a    (Ain),
        .b    (Bin),
        .prod (prod)
    );

    // Carry out of the top bit is dropped on purpose: the accumulator wraps.
    assign prod_ext = {{DATA_WIDTH{1'b0}}, prod};
    assign sum      = acc + prod_ext;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        acc_op   = ACC_HOLD;
        acc_next = acc;
        if (Clr) begin
            acc_op = ACC_CLEAR;
        end else if (En) begin
            acc_op = ACC_ADD;
        end

        case (acc_op)
            ACC_CLEAR: acc_next = '0;
            ACC_ADD:   acc_next = sum;
            default:   acc_next = acc;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments; reset is tested inside the clocked block, so it takes effect only at a rising edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc <= '0;
        end else begin
            acc <= acc_next;
        end
    end

    assign Cout = acc;

endmodule

// File: tb/tb_mac_unit.sv
// Self-checking bench for mac_unit: directed vector table, randomized alternating-enable run
// against a plain-arithmetic running-sum model, and a wrap-around sequence.
module tb_mac_unit;

    localparam int DW = 8;
    localparam int AW = 3 * DW;
    localparam longint MOD = longint'(1) << AW;

    logic          clk;
    logic          rst_n;
    logic          En;
    logic          Clr;
    logic [DW-1:0] Ain;
    logic [DW-1:0] Bin;
    logic [AW-1:0] Cout;

    int n_tests;
    int n_fail;

    typedef struct {
        string         name;
        logic          rst_n;
        logic          en;
        logic          clr;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [AW-1:0] exp;
    } vec_t;

    vec_t vecs[$];

    mac_unit #(
        .DATA_WIDTH (DW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .En    (En),
        .Clr   (Clr),
        .Ain   (Ain),
        .Bin   (Bin),
        .Cout  (Cout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%06h, expected 0x%06h", name, act, exp);
        end
    endtask

    // Drive one set of inputs, let one rising edge pass, then settle before sampling.
    task automatic step(input logic r, input logic e, input logic c,
                        input logic [DW-1:0] a, input logic [DW-1:0] b);
        rst_n = r;
        En    = e;
        Clr   = c;
        Ain   = a;
        Bin   = b;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic r, input logic e, input logic c,
                                input logic [DW-1:0] a, input logic [DW-1:0] b,
                                input logic [AW-1:0] exp);
        vec_t v;
        v.name  = name;
        v.rst_n = r;
        v.en    = e;
        v.clr   = c;
        v.a     = a;
        v.b     = b;
        v.exp   = exp;
        return v;
    endfunction

    initial begin
        longint        ref_sum;
        logic [DW-1:0] ra;
        logic [DW-1:0] rb;
        logic [AW-1:0] held;

        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        En      = 1'b0;
        Clr     = 1'b0;
        Ain     = '0;
        Bin     = '0;

        // Directed vectors: reset, release, first product, clear with enable, hold, reset overriding enable.
        for (int i = 0; i < 5; i++) vecs.push_back(mk("reset_hold", 1'b0, 1'b0, 1'b0, 8'h12, 8'h34, 24'h0));
        vecs.push_back(mk("release_idle",   1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 24'h000000));
        vecs.push_back(mk("first_mac",      1'b1, 1'b1, 1'b0, 8'h12, 8'h34, 24'h0003A8));
        vecs.push_back(mk("clr_with_en",    1'b1, 1'b1, 1'b1, 8'h12, 8'h34, 24'h000000));
        vecs.push_back(mk("mac_3x4",        1'b1, 1'b1, 1'b0, 8'h03, 8'h04, 24'h00000C));
        vecs.push_back(mk("clr_no_en",      1'b1, 1'b0, 1'b1, 8'hAA, 8'hBB, 24'h000000));
        vecs.push_back(mk("mac_max",        1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF, 24'h00FE01));
        vecs.push_back(mk("hold_en0",       1'b1, 1'b0, 1'b0, 8'h55, 8'h77, 24'h00FE01));
        vecs.push_back(mk("mac_1x1",        1'b1, 1'b1, 1'b0, 8'h01, 8'h01, 24'h00FE02));
        vecs.push_back(mk("rst_over_en",    1'b0, 1'b1, 1'b0, 8'hFF, 8'hFF, 24'h000000));
        vecs.push_back(mk("rst_over_clr",   1'b0, 1'b1, 1'b1, 8'hFF, 8'hFF, 24'h000000));
        vecs.push_back(mk("restart_from_0", 1'b1, 1'b1, 1'b0, 8'h02, 8'h03, 24'h000006));
        vecs.push_back(mk("accum_again",    1'b1, 1'b1, 1'b0, 8'h10, 8'h10, 24'h000106));

        foreach (vecs[i]) begin
            step(vecs[i].rst_n, vecs[i].en, vecs[i].clr, vecs[i].a, vecs[i].b);
            check(vecs[i].name, Cout, vecs[i].exp);
        end

        // Randomized run: enabled edge then disabled edge, checked against a running sum.
        step(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        check("rand_start_clear", Cout, '0);
        ref_sum = 0;
        for (int cyc = 0; cyc < 226; cyc += 2) begin
            ra = DW'($urandom_range(0, 127));
            rb = DW'($urandom_range(0, 127));
            ref_sum = (ref_sum + longint'(ra) * longint'(rb)) % MOD;
            step(1'b1, 1'b1, 1'b0, ra, rb);
            check("rand_enabled", Cout, AW'(ref_sum));
            held = Cout;
            step(1'b1, 1'b0, 1'b0, DW'($urandom_range(0, 127)), DW'($urandom_range(0, 127)));
            check("rand_disabled", Cout, held);
            check("rand_disabled_ref", Cout, AW'(ref_sum));
        end

        // Wrap-around: 258*255*255 + 255*3 = 0xFFFFFF, then one more product of 2.
        step(1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 258; i++) step(1'b1, 1'b1, 1'b0, 8'hFF, 8'hFF);
        step(1'b1, 1'b1, 1'b0, 8'hFF, 8'h03);
        check("preload_full", Cout, 24'hFFFFFF);
        step(1'b1, 1'b1, 1'b0, 8'h01, 8'h02);
        check("wrap_around", Cout, 24'h000001);

        // Reset while enabled with a nonzero sum, then accumulation restarts from zero.
        step(1'b0, 1'b1, 1'b0, 8'h40, 8'h40);
        check("rst_mid_accum", Cout, 24'h000000);
        step(1'b1, 1'b1, 1'b0, 8'h07, 8'h09);
        check("post_rst_add", Cout, 24'h00003F);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
